// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 256x32 SRAM macro port between a wishbone
// slot (one outstanding access) and a streaming reader (up to one read/clk).
module sram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_wdata,
    input  logic [DW/8-1:0] wb_wmsk,
    input  logic            wb_we,
    input  logic            wb_cyc,
    output logic            wb_ack,
    output logic [DW-1:0]   wb_rdata,
    input  logic            st_req,
    input  logic [AW-1:0]   st_addr,
    output logic            st_gnt,
    output logic            st_valid,
    output logic [DW-1:0]   st_rdata,
    output logic            ram_csb,
    output logic            ram_web,
    output logic [DW/8-1:0] ram_wmask,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic own_w;
        logic wr;
    } tag_t;

    logic                 wb_busy;
    logic                 last_w;
    logic                 w_elig, s_elig;
    logic                 gnt_w, gnt_s;
    logic [STAGES:1]      vld_pipe;
    tag_t [STAGES:1]      tag_pipe;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        w_elig = wb_cyc & ~wb_busy;
        s_elig = st_req;
        gnt_w  = w_elig & (~s_elig | ~last_w);
        gnt_s  = s_elig & ~gnt_w;
    end

    assign st_gnt = gnt_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_busy   <= 1'b0;
            last_w    <= 1'b0;
            ram_csb   <= 1'b1;
            ram_web   <= 1'b1;
            ram_wmask <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            vld_pipe  <= '0;
            tag_pipe  <= '0;
        end else begin
            ram_csb   <= ~(gnt_w | gnt_s);
            ram_web   <= ~(gnt_w & wb_we);
            ram_wmask <= (gnt_w & wb_we) ? wb_wmsk : '0;
            if (gnt_w) begin
                ram_addr <= wb_addr;
                if (wb_we) ram_din <= wb_wdata;
            end else if (gnt_s) begin
                ram_addr <= st_addr;
            end
            if (gnt_w | gnt_s) last_w <= gnt_w;
            // Busy survives a held cyc after ack so the same cycle is not re-issued.
            if (gnt_w)        wb_busy <= 1'b1;
            else if (!wb_cyc) wb_busy <= 1'b0;
            vld_pipe[1]       <= gnt_w | gnt_s;
            tag_pipe[1].own_w <= gnt_w;
            tag_pipe[1].wr    <= gnt_w & wb_we;
            for (int i = 2; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_comb begin
        wb_ack   = vld_pipe[STAGES] & tag_pipe[STAGES].own_w;
        st_valid = vld_pipe[STAGES] & ~tag_pipe[STAGES].own_w;
        wb_rdata = (wb_ack & ~tag_pipe[STAGES].wr) ? ram_dout : '0;
        st_rdata = st_valid ? ram_dout : '0;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single read/write port of the 256x32 sky130 SRAM macro between two requesters:
  - Port W: the local wishbone slave slot (cyc/ack style) driven by the bus splitter.
  - Port S: a streaming read requester such as the audio or video sample fetcher.
- Round-robin arbitration, registered macro command, fixed 2-cycle response latency.
- Sits between the splitter RAM slot and the SRAM macro; replaces ad-hoc ack and write-enable logic.

Parameters:
- AW, 8, SRAM word address width.
- DW, 32, data width. Fixed at 32; byte mask is DW/8 = 4 bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_addr  in  AW  port W word address.
- wb_wdata  in  DW  port W write data.
- wb_wmsk  in  4  port W byte enables, active high.
- wb_we  in  1  port W write (1) / read (0).
- wb_cyc  in  1  port W request; held high until wb_ack.
- wb_ack  out  1  port W completion pulse.
- wb_rdata  out  DW  port W read data; 0 when wb_ack is low.
- st_req  in  1  port S read request, level.
- st_addr  in  AW  port S read address.
- st_gnt  out  1  port S request accepted this cycle.
- st_valid  out  1  port S read data valid pulse.
- st_rdata  out  DW  port S read data; 0 when st_valid is low.
- ram_csb  out  1  macro chip select, active low.
- ram_web  out  1  macro write enable, active low.
- ram_wmask  out  4  macro byte mask, active high.
- ram_addr  out  AW  macro address.
- ram_din  out  DW  macro write data.
- ram_dout  in  DW  macro read data; valid the cycle after the command edge.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except ram_csb=1 and ram_web=1. Internal state cleared: wb_busy=0, last=S, pipeline valid bits=0.
- Reset mid-operation: in-flight accesses are dropped. No ack or valid is emitted for them.
- Eligibility, evaluated combinationally in cycle N:
  - W is eligible when wb_cyc=1 and wb_busy=0.
  - S is eligible when st_req=1.
- Arbitration:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not granted last. The `last` register updates on every grant.
- st_gnt is high in cycle N when S is granted. The requester may present a new st_addr in cycle N+1.
- Issue: at the edge ending cycle N, register the command.
  - Always: ram_csb=0, ram_addr = granted address.
  - W write: ram_web=0, ram_wmask=wb_wmsk, ram_din=wb_wdata.
  - Otherwise: ram_web=1, ram_wmask=0.
  - No grant: ram_csb=1, ram_web=1, ram_wmask=0. ram_addr and ram_din hold their previous values.
- Pipeline: a 2-stage shift of {valid, owner, is_write} tracks each issued command.
- Response in cycle N+2:
  - W: wb_ack=1. wb_rdata=ram_dout for reads, 0 for writes.
  - S: st_valid=1, st_rdata=ram_dout.
- Throughput: S can be granted every cycle, up to 1 read/clk. W is limited to one outstanding access.
- wb_busy is set at the W issue edge. It clears only at an edge where wb_cyc=0.
  - This prevents re-issue while the splitter still holds cyc during or after the ack cycle.
- Read-after-write: a W write followed by an S read to the same address returns the new data. The macro serialises the accesses; no bypass is needed.
- Simultaneous wb_ack and st_valid cannot occur, because only one command issues per cycle.
- Address inputs are sampled only in the grant cycle.

Test Plan:
- Reset then idle:
  - Required: ram_csb=1, ram_web=1, all acks/valids 0.
  - Assert rst_n=0 for 1 cycle mid-read. Required: no wb_ack follows.
- W write addr 0x12, data 0xDEADBEEF, wmsk 0xF, then W read 0x12:
  - Write issue: ram_web=0 one cycle after cyc.
  - wb_ack 2 cycles after the cyc rising edge, wb_rdata=0.
  - Read: wb_ack with wb_rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 mask 0x3 over 0xDEADBEEF, then read.
  - Required: 0xDEAD3344.
- S streaming: st_req held, st_addr 0..7 advanced on each st_gnt.
  - Required: st_gnt high 8 consecutive cycles.
  - Required: st_valid high 8 consecutive cycles starting 2 cycles after the first st_gnt, data in address order.
- Contention: st_req held continuously while W read issued.
  - Required: grants alternate; W served within 2 cycles of cyc.
  - Required: S loses exactly one slot; no S read lost or duplicated.
- Holdoff: wb_cyc held high for 3 cycles after wb_ack.
  - Required: no second W issue until wb_cyc drops and rises again.
